// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer; owns PC, IR and the retire counter.
// Optional CPU_SINGLE_STEP_EN adds a step input: one instruction per pulse, always back to idle.
module cpu_sequencer #(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned INSTR_W  = 16,
    parameter int unsigned RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
`ifdef CPU_SINGLE_STEP_EN
    input  logic                step,
`endif
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_valid,
    input  logic [INSTR_W-1:0]  imem_data,
    output logic [INSTR_W-1:0]  instr,
    input  logic                ctrl_write_en,
    input  logic                ctrl_branch_sel,
    input  logic                alu_cond,
    input  logic [PC_W-1:0]     branch_target,
    output logic                alu_latch,
    output logic                rf_we,
    output logic [PC_W-1:0]     pc,
    output logic                busy,
    output logic [RETIRE_W-1:0] retired
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecute,
        StWriteback
    } state_e;

    state_e               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [RETIRE_W-1:0]  retired_q, retired_d;
    logic [PC_W-1:0]      pc_inc;
    logic                 retire;
    logic                 start;
    logic                 keep_running;

`ifdef CPU_SINGLE_STEP_EN
    assign start        = step;
    assign keep_running = 1'b0;
`else
    assign start        = run;
    assign keep_running = run;
`endif

    assign pc_inc    = pc_q + PC_W'(1);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign instr     = instr_q;
    assign retired   = retired_q;
    assign busy      = (state_q != StIdle);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        retire    = 1'b0;
        imem_req  = 1'b0;
        alu_latch = 1'b0;
        rf_we     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) state_d = StFetch;
            end
            StFetch: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    instr_d = imem_data;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                state_d = StExecute;
            end
            StExecute: begin
                alu_latch = 1'b1;
                // Branch select wins over write enable: a jump never writes the register file.
                if (ctrl_branch_sel) begin
                    pc_d   = alu_cond ? branch_target : pc_inc;
                    retire = 1'b1;
                end else if (ctrl_write_en) begin
                    state_d = StWriteback;
                end else begin
                    pc_d   = pc_inc;
                    retire = 1'b1;
                end
            end
            StWriteback: begin
                rf_we  = 1'b1;
                pc_d   = pc_inc;
                retire = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (retire) begin
            retired_d = retired_q + RETIRE_W'(1);
            state_d   = keep_running ? StFetch : StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            instr_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

endmodule
